// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues pc to instruction memory under a credit limit,
// tags responses with their fetch address and buffers them in order for decode.
module ifetch_queue #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] pc,
   output logic        pc_adv,
   input  logic        redirect,
   output logic        imem_req,
   output logic [31:2] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:2] inst_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

   typedef enum logic {FETCH, FLUSH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] count, outst, drop;
   logic [CW-1:0] count_nxt, outst_nxt, drop_nxt;
   logic [AW-1:0] pend_wr, pend_rd, q_wr, q_rd;
   logic [31:2]   pend_addr [DEPTH];
   logic [31:0]   q_inst    [DEPTH];
   logic [31:2]   q_pc      [DEPTH];
   logic [CW:0]   used;
   logic          grant, resp, push, pop;

   assign imem_addr  = pc;
   assign inst_valid = (count != '0);
   assign inst       = q_inst[q_rd];
   assign inst_pc    = q_pc[q_rd];
   assign pc_adv     = grant;

   always_comb begin
      used     = {1'b0, count} + {1'b0, outst};
      imem_req = !reset && (state == FETCH) && !redirect && (used < CREDITS);
      grant    = imem_req & imem_gnt;
      // rvalid with nothing outstanding is a protocol error and is ignored
      resp     = imem_rvalid && (outst != '0);
      push     = resp && !redirect && (drop == '0);
      pop      = inst_valid && inst_ready && !redirect;
   end

   always_comb begin
      state_nxt = state;
      drop_nxt  = drop;
      outst_nxt = outst + CW'(grant) - CW'(resp);
      count_nxt = redirect ? '0 : count + CW'(push) - CW'(pop);
      case (state)
         FETCH: begin
            if (redirect) begin
               drop_nxt = outst - CW'(resp);
               if (drop_nxt != '0) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (resp && (drop != '0)) drop_nxt = drop - CW'(1);
            if (drop_nxt == '0) state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         count   <= '0;
         outst   <= '0;
         drop    <= '0;
         pend_wr <= '0;
         pend_rd <= '0;
         q_wr    <= '0;
         q_rd    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_addr[i] <= '0;
            q_inst[i]    <= '0;
            q_pc[i]      <= '0;
         end
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         outst <= outst_nxt;
         drop  <= drop_nxt;
         if (grant) begin
            pend_addr[pend_wr] <= pc;
            pend_wr            <= pend_wr + AW'(1);
         end
         if (resp) pend_rd <= pend_rd + AW'(1);
         if (push) begin
            q_inst[q_wr] <= imem_rdata;
            q_pc[q_wr]   <= pend_addr[pend_rd];
            q_wr         <= q_wr + AW'(1);
         end
         // a redirect empties the queue by catching the read pointer up
         if (redirect)  q_rd <= q_wr;
         else if (pop)  q_rd <= q_rd + AW'(1);
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: the bench plays PC register and memory,
// expected instructions go to a scoreboard checked by a separate monitor.
module tb_ifetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] pc;
   logic        pc_adv;
   logic        redirect;
   logic        imem_req;
   logic [31:2] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:2] inst_pc;

   ifetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pc(pc), .pc_adv(pc_adv), .redirect(redirect),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   logic [31:2] mem_q [$];
   logic [31:2] exp_q [$];
   logic [31:2] mon_e;
   bit          resp_en, chk_ctl, chk_vld, chk_empty, done;
   logic        exp_req, exp_adv, exp_vld;
   logic [31:2] exp_addr;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, want);
      end
   endtask

   // monitor: scoreboard pops on every accepted instruction, plus per-cycle expectations
   always @(negedge clk) begin
      if (inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst at %0t: actual inst_pc=%h required=none", $time, inst_pc);
         end else begin
            mon_e = exp_q.pop_front();
            check("inst_pc", {2'b00, inst_pc}, {2'b00, mon_e});
            check("inst", inst, {2'b00, mon_e});
         end
      end
      if (chk_ctl) begin
         check("imem_req", 32'(imem_req), 32'(exp_req));
         check("pc_adv", 32'(pc_adv), 32'(exp_adv));
         if (exp_req) check("imem_addr", {2'b00, imem_addr}, {2'b00, exp_addr});
      end
      if (chk_vld) check("inst_valid", 32'(inst_valid), 32'(exp_vld));
      if (chk_empty) begin
         check("reset_inst", inst, 32'h0);
         check("reset_inst_pc", {2'b00, inst_pc}, 32'h0);
      end
      if (done) begin
         check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   task automatic expect_ctl(input logic r, input logic a, input logic [31:2] addr);
      chk_ctl  = 1'b1;
      exp_req  = r;
      exp_adv  = a;
      exp_addr = addr;
   endtask

   task automatic expect_vld(input logic v);
      chk_vld = 1'b1;
      exp_vld = v;
   endtask

   // one clock: sample grants at negedge, then act as PC register and zero-wait memory
   task automatic tick();
      logic adv;
      @(negedge clk);
      adv = pc_adv;
      if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
      @(posedge clk);
      #1;
      chk_ctl   = 1'b0;
      chk_vld   = 1'b0;
      chk_empty = 1'b0;
      if (adv) pc = pc + 30'd1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (resp_en && mem_q.size() != 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = {2'b00, mem_q.pop_front()};
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; pc = '0; redirect = 1'b0; imem_gnt = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b1; resp_en = 1'b1;
      chk_ctl = 1'b0; chk_vld = 1'b0; chk_empty = 1'b0; done = 1'b0;
      exp_req = 1'b0; exp_adv = 1'b0; exp_vld = 1'b0; exp_addr = '0;

      // reset state
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b0); chk_empty = 1'b1; tick();
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b0); chk_empty = 1'b1; tick();
      reset = 1'b0;

      // streaming with zero-wait memory
      for (int k = 0; k < 8; k++) exp_q.push_back(30'(k));
      for (int k = 0; k < 8; k++) begin
         expect_ctl(1'b1, 1'b1, 30'(k)); expect_vld(k >= 2); tick();
      end
      imem_gnt = 1'b0;
      expect_ctl(1'b1, 1'b0, 30'h8); expect_vld(1'b1); tick();
      expect_vld(1'b1); tick();
      // grant held low: address stable, no advance, no queue activity
      for (int k = 0; k < 3; k++) begin
         expect_ctl(1'b1, 1'b0, 30'h8); expect_vld(1'b0); tick();
      end

      // decode stalled: credits stop requests at DEPTH
      inst_ready = 1'b0; imem_gnt = 1'b1;
      for (int k = 8; k < 16; k++) exp_q.push_back(30'(k));
      for (int k = 0; k < 7; k++) begin
         expect_ctl(k < 4, k < 4, 30'(8 + k)); expect_vld(k >= 2); tick();
      end
      inst_ready = 1'b1;
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b1); tick();
      for (int k = 1; k <= 4; k++) begin
         expect_ctl(1'b1, 1'b1, 30'(11 + k)); tick();
      end
      imem_gnt = 1'b0;
      for (int k = 0; k < 4; k++) tick();

      // redirect with two fetches in flight
      resp_en = 1'b0; imem_gnt = 1'b1;
      exp_q.push_back(30'h100);
      expect_ctl(1'b1, 1'b1, 30'h010); tick();
      expect_ctl(1'b1, 1'b1, 30'h011); tick();
      redirect = 1'b1; pc = 30'h100; resp_en = 1'b1;
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b0); tick();
      redirect = 1'b0;
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b0); tick();
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b0); tick();
      expect_ctl(1'b1, 1'b1, 30'h100); tick();
      imem_gnt = 1'b0;
      for (int k = 0; k < 3; k++) tick();

      // redirect coinciding with the last outstanding response
      pc = 30'h010; imem_gnt = 1'b1;
      exp_q.push_back(30'h010);
      exp_q.push_back(30'h200);
      expect_ctl(1'b1, 1'b1, 30'h010); tick();
      expect_ctl(1'b1, 1'b1, 30'h011); tick();
      redirect = 1'b1; pc = 30'h200;
      expect_ctl(1'b0, 1'b0, '0); tick();
      redirect = 1'b0;
      expect_ctl(1'b1, 1'b1, 30'h200); tick();
      imem_gnt = 1'b0;
      for (int k = 0; k < 3; k++) tick();

      // reset pulse with queue loaded and one fetch outstanding
      inst_ready = 1'b0; imem_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expect_ctl(1'b1, 1'b1, 30'(32'h201 + k));
         if (k == 3) expect_vld(1'b1);
         tick();
      end
      reset = 1'b1; mem_q.delete(); resp_en = 1'b0; imem_gnt = 1'b0;
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b0); chk_empty = 1'b1; tick();
      reset = 1'b0; inst_ready = 1'b1; resp_en = 1'b1;
      mem_q.push_back(30'h3ff);
      expect_ctl(1'b1, 1'b0, 30'h205); expect_vld(1'b0); tick();
      expect_ctl(1'b1, 1'b0, 30'h205); expect_vld(1'b0); tick();
      imem_gnt = 1'b1; inst_ready = 1'b0;
      for (int k = 0; k < 4; k++) exp_q.push_back(30'(32'h205 + k));
      for (int k = 0; k < 4; k++) begin
         expect_ctl(1'b1, 1'b1, 30'(32'h205 + k));
         if (k == 0) expect_vld(1'b0);
         tick();
      end
      expect_ctl(1'b0, 1'b0, '0); expect_vld(1'b1); tick();
      imem_gnt = 1'b0; inst_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();

      done = 1'b1;
      tick();
   end

endmodule
